rst_seq_pynqz2: RTL and testbench

Reset sequencer directly downstream of the board clock generator. Runs on `clk_sys`, takes that stage's combined reset plus the raw PLL lock, pushbutton and debugger reset request, and drives staged, registered resets: peripherals first, CPU core later. Also reports the cause of the last reset. Its outputs replace the direct use of the combined reset inside the SoC top.

---
 rtl/rst_seq_pkg.sv | 5 +
 rtl/rst_btn_debounce.sv | 30 +++
 rtl/rst_seq_pynqz2.sv | 86 ++++++++
 tb/tb_rst_seq_pynqz2.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state and reset-cause encodings for the reset sequencer
package rst_seq_pkg;
  typedef enum logic [1:0] {HOLD, STAGGER, RUN} rst_state_e;
  typedef enum logic [1:0] {POR, LOCK, BTN, DBG} rst_cause_e;
endpackage

// File: rtl/rst_btn_debounce.sv
// rst_btn_debounce: synchronises the reset pushbutton and accepts only level changes stable for DEBOUNCE_CYCLES
module rst_btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_sys,
  input  logic rst_sys_n,
  input  logic btn_n,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic btn_s;
  assign btn_s = sync[SYNC_STAGES-1];
  // flip on the edge the count would reach the limit so the press reaches the FSM without an extra cycle
  always_ff @(posedge clk_sys)
    if (!rst_sys_n) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_n};
      if (btn_s == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= btn_s;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/rst_seq_pynqz2.sv
// rst_seq_pynqz2: staged peripheral/CPU reset release with last-reset-cause reporting
module rst_seq_pynqz2
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 8
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  input  logic       pll_locked_i,
  input  logic       btn_rst_n_i,
  input  logic       ndm_rst_req_i,
  output logic       rst_periph_n_o,
  output logic       rst_cpu_n_o,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int CW = HW > SW ? HW : SW;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic lock_s, btn_level, pressed, trigger;
  logic periph_d, cpu_d;
  logic [CW-1:0] cnt, cnt_d;
  rst_state_e state, state_d;
  rst_cause_e cause, cause_d;
  assign lock_s  = lock_sync[SYNC_STAGES-1];
  assign pressed = !btn_level;
  assign trigger = !lock_s || pressed || ndm_rst_req_i;
  rst_btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_sys  (clk_sys),
    .rst_sys_n(rst_sys_n),
    .btn_n    (btn_rst_n_i),
    .level    (btn_level)
  );
  always_ff @(posedge clk_sys)
    if (!rst_sys_n) begin
      lock_sync      <= '0;
      state          <= HOLD;
      cnt            <= '0;
      cause          <= POR;
      rst_periph_n_o <= 1'b0;
      rst_cpu_n_o    <= 1'b0;
      rst_done_o     <= 1'b0;
      rst_cause_o    <= 2'd0;
    end else begin
      lock_sync      <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      state          <= state_d;
      cnt            <= cnt_d;
      cause          <= cause_d;
      rst_periph_n_o <= periph_d;
      rst_cpu_n_o    <= cpu_d;
      rst_done_o     <= cpu_d;
      rst_cause_o    <= cause;
    end
  // cause is only recorded on leaving STAGGER/RUN; repeated events in HOLD just restart the count
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    cause_d = cause;
    if (state == HOLD) begin
      if (trigger) cnt_d = '0;
      else if (cnt == CW'(HOLD_CYCLES - 1)) begin
        state_d = STAGGER;
        cnt_d   = '0;
      end
    end else if (trigger) begin
      state_d = HOLD;
      cnt_d   = '0;
      cause_d = !lock_s ? LOCK : pressed ? BTN : DBG;
    end else if (state == RUN) cnt_d = '0;
    else if (cnt == CW'(STAGGER_CYCLES - 1)) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end
  always_comb begin
    periph_d = state != HOLD;
    cpu_d    = state == RUN;
  end
endmodule

// File: tb/tb_rst_seq_pynqz2.sv
// tb_rst_seq_pynqz2: directed edge-accurate checks of the reset sequencer
module tb_rst_seq_pynqz2;
  logic clk = 1'b0;
  logic rst_sys_n = 1'b0;
  logic pll_locked_i = 1'b1;
  logic btn_rst_n_i = 1'b1;
  logic ndm_rst_req_i = 1'b0;
  logic rst_periph_n_o, rst_cpu_n_o, rst_done_o;
  logic [1:0] rst_cause_o;
  int tests = 0;
  int fails = 0;

  rst_seq_pynqz2 #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(20),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (8)
  ) dut (
    .clk_sys       (clk),
    .rst_sys_n     (rst_sys_n),
    .pll_locked_i  (pll_locked_i),
    .btn_rst_n_i   (btn_rst_n_i),
    .ndm_rst_req_i (ndm_rst_req_i),
    .rst_periph_n_o(rst_periph_n_o),
    .rst_cpu_n_o   (rst_cpu_n_o),
    .rst_done_o    (rst_done_o),
    .rst_cause_o   (rst_cause_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  initial begin
    step(3);
    check("rst_periph", rst_periph_n_o, 0);
    check("rst_cpu", rst_cpu_n_o, 0);
    check("rst_done", rst_done_o, 0);
    check("rst_cause", rst_cause_o, 0);
    // power-on: edge 0 is the next edge
    rst_sys_n = 1'b1;
    step(18);
    check("por_periph_e17", rst_periph_n_o, 0);
    step(1);
    check("por_periph_e18", rst_periph_n_o, 1);
    check("por_cpu_e18", rst_cpu_n_o, 0);
    step(7);
    check("por_cpu_e25", rst_cpu_n_o, 0);
    check("por_done_e25", rst_done_o, 0);
    step(1);
    check("por_cpu_e26", rst_cpu_n_o, 1);
    check("por_done_e26", rst_done_o, 1);
    check("por_cause", rst_cause_o, 0);
    // lock low for 50 cycles after reset release
    rst_sys_n = 1'b0;
    pll_locked_i = 1'b0;
    step(2);
    check("rst_again_periph", rst_periph_n_o, 0);
    rst_sys_n = 1'b1;
    step(50);
    check("lock_low_periph", rst_periph_n_o, 0);
    pll_locked_i = 1'b1;
    step(18);
    check("lock_up_periph_17", rst_periph_n_o, 0);
    step(1);
    check("lock_up_periph_18", rst_periph_n_o, 1);
    step(8);
    check("lock_up_cpu", rst_cpu_n_o, 1);
    // lock loss in RUN
    pll_locked_i = 1'b0;
    step(3);
    check("lockloss_periph_2", rst_periph_n_o, 1);
    step(1);
    check("lockloss_periph_3", rst_periph_n_o, 0);
    check("lockloss_cpu_3", rst_cpu_n_o, 0);
    check("lockloss_done_3", rst_done_o, 0);
    check("lockloss_cause", rst_cause_o, 1);
    pll_locked_i = 1'b1;
    step(18);
    check("relock_periph_17", rst_periph_n_o, 0);
    step(1);
    check("relock_periph_18", rst_periph_n_o, 1);
    step(8);
    check("relock_cpu", rst_cpu_n_o, 1);
    // bounces then a stable press
    for (int i = 0; i < 3; i++) begin
      btn_rst_n_i = 1'b0;
      step(5);
      btn_rst_n_i = 1'b1;
      step(5);
    end
    check("bounce_periph", rst_periph_n_o, 1);
    check("bounce_done", rst_done_o, 1);
    btn_rst_n_i = 1'b0;
    step(23);
    check("press_periph_22", rst_periph_n_o, 1);
    step(1);
    check("press_periph_23", rst_periph_n_o, 0);
    check("press_cpu_23", rst_cpu_n_o, 0);
    check("press_cause", rst_cause_o, 2);
    step(16);
    btn_rst_n_i = 1'b1;
    step(60);
    check("release_cpu", rst_cpu_n_o, 1);
    check("release_cause", rst_cause_o, 2);
    // debugger reset pulse
    ndm_rst_req_i = 1'b1;
    step(1);
    ndm_rst_req_i = 1'b0;
    check("dbg_periph_0", rst_periph_n_o, 1);
    step(1);
    check("dbg_periph_1", rst_periph_n_o, 0);
    check("dbg_cpu_1", rst_cpu_n_o, 0);
    check("dbg_cause", rst_cause_o, 3);
    step(15);
    check("dbg_periph_16", rst_periph_n_o, 0);
    step(1);
    check("dbg_periph_17", rst_periph_n_o, 1);
    check("dbg_cpu_17", rst_cpu_n_o, 0);
    step(7);
    check("dbg_cpu_24", rst_cpu_n_o, 0);
    step(1);
    check("dbg_cpu_25", rst_cpu_n_o, 1);
    // system reset while in STAGGER
    ndm_rst_req_i = 1'b1;
    step(1);
    ndm_rst_req_i = 1'b0;
    step(17);
    check("stag_periph", rst_periph_n_o, 1);
    check("stag_cpu", rst_cpu_n_o, 0);
    rst_sys_n = 1'b0;
    step(1);
    check("stag_rst_periph", rst_periph_n_o, 0);
    check("stag_rst_cpu", rst_cpu_n_o, 0);
    check("stag_rst_done", rst_done_o, 0);
    check("stag_rst_cause", rst_cause_o, 0);
    rst_sys_n = 1'b1;
    step(27);
    check("rerun_cpu", rst_cpu_n_o, 1);
    // debug pulse coincident with synchronised lock loss
    pll_locked_i = 1'b0;
    step(2);
    ndm_rst_req_i = 1'b1;
    step(1);
    ndm_rst_req_i = 1'b0;
    step(1);
    check("both_periph", rst_periph_n_o, 0);
    check("both_cause", rst_cause_o, 1);
    ndm_rst_req_i = 1'b1;
    step(1);
    ndm_rst_req_i = 1'b0;
    step(2);
    check("hold_dbg_cause", rst_cause_o, 1);
    pll_locked_i = 1'b1;
    step(30);
    check("final_cpu", rst_cpu_n_o, 1);
    check("final_done", rst_done_o, 1);
    check("final_cause", rst_cause_o, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
